// File: rtl/adder_serial_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding,
// slice width and counter sizing helper.
package adder_serial_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_4bits.sv
// Combinational 4-bit adder slice with carry in/out; the only adder in the datapath.
module adder_4bits
  import adder_serial_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/adder_serial_ctrl.sv
// Nibble-serial adder: captures A, B and cin on start, then resolves one 4-bit
// slice per cycle through a single shared adder, rippling the carry in a register.
module adder_serial_ctrl
  import adder_serial_pkg::*;
#(
  parameter  int N_NIBBLES = 4,
  localparam int W         = SLICE_W * N_NIBBLES
) (
  input  logic         i_w_clk,
  input  logic         i_w_rst_n,
  input  logic         i_w_start,
  input  logic         i_w_abort,
  input  logic [W-1:0] i_w_a,
  input  logic [W-1:0] i_w_b,
  input  logic         i_w_cin,
  output logic [W-1:0] o_w_s,
  output logic         o_w_cout,
  output logic         o_w_busy,
  output logic         o_w_done
);

  localparam int                 CNT_W    = cnt_width(N_NIBBLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_NIBBLES - 1);

  state_t                                 state;
  logic [CNT_W-1:0]                       cnt;
  logic                                   carry;
  logic [N_NIBBLES-1:0][SLICE_W-1:0]      a_reg;
  logic [N_NIBBLES-1:0][SLICE_W-1:0]      b_reg;
  logic [N_NIBBLES-1:0][SLICE_W-1:0]      s_reg;
  logic [SLICE_W-1:0]                     slice_sum;
  logic                                   slice_cout;

  adder_4bits u_adder (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cin  (carry),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  assign o_w_s    = s_reg;
  assign o_w_busy = (state != ST_IDLE);

  // NOTE: every register here, operand copies included, is assigned with <= so all
  // of them see pre-edge values of state/cnt; blocking writes would race the adder inputs.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      o_w_cout <= 1'b0;
      o_w_done <= 1'b0;
    end else begin
      o_w_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Abort is meaningless here, so a coincident start always wins.
          if (i_w_start) begin
            a_reg    <= i_w_a;
            b_reg    <= i_w_b;
            carry    <= i_w_cin;
            s_reg    <= '0;
            o_w_cout <= 1'b0;
            cnt      <= '0;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (i_w_abort) begin
            s_reg    <= '0;
            o_w_cout <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            state    <= ST_IDLE;
          end else begin
            s_reg[cnt] <= slice_sum;
            carry      <= slice_cout;
            if (cnt == CNT_LAST) begin
              o_w_cout <= slice_cout;
              o_w_done <= 1'b1;
              cnt      <= '0;
              state    <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
